pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Registered program-counter sequencer for the fetch stage of the five-stage MIPS pipeline.
- Generalises the plain PC-plus-small-increment adder into a parametrised, clocked unit.
- Handles:
  - variable increment
  - signed branch offset
  - absolute jump
  - stall hold
  - a one-cycle redirect bubble
- Drives the instruction-memory address and a fetch-valid qualifier.

Parameters:
- PC_W, 8: program-counter width in bits.
- INC_W, 3: width of the unsigned increment input.
- OFF_W, 8: width of the signed branch offset, two's complement.
- RESET_PC, 0: PC value loaded on reset. Must fit in PC_W.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- stall_i, input, 1: hold the PC; the fetch stage cannot accept.
- inc_i, input, INC_W: unsigned step added each advancing cycle.
- br_taken_i, input, 1: branch taken; redirect to pc_o + sext(br_off_i).
- br_off_i, input, OFF_W: signed branch offset.
- jmp_i, input, 1: absolute jump request.
- jmp_tgt_i, input, PC_W: jump target.
- pc_o, output, PC_W: current fetch address (registered).
- pc_valid_o, output, 1: pc_o is a valid fetch this cycle.
- redirect_o, output, 1: one-cycle pulse when a jump or branch is accepted.

Behaviour:
- Reset is asynchronous on rst_n low. All outputs and state are registered.
  - pc_o = RESET_PC, pc_valid_o = 0, redirect_o = 0, state = BOOT.
- State BOOT:
  - First clock after reset release → state RUN, pc_valid_o = 1, pc_o unchanged (RESET_PC).
  - Control inputs are ignored while in BOOT.
- State RUN, evaluated each clock. Priority is jump > branch > stall > increment.
  - jmp_i = 1: pc_o ← jmp_tgt_i; redirect_o ← 1; pc_valid_o ← 0; state → REDIR.
  - br_taken_i = 1: pc_o ← (pc_o + sext(br_off_i)) mod 2^PC_W; redirect_o ← 1; pc_valid_o ← 0; state → REDIR.
  - stall_i = 1: pc_o held, pc_valid_o held at 1, state → HOLD.
  - Otherwise: pc_o ← (pc_o + zext(inc_i)) mod 2^PC_W.
- State HOLD:
  - pc_o is held while stall_i = 1.
  - stall_i = 0 → RUN without advancing that cycle. The held address is fetched once more.
  - A jump or branch in HOLD is accepted with the same priority as in RUN. It overrides the stall.
- State REDIR:
  - Exactly one bubble cycle. pc_valid_o = 0, redirect_o ← 0.
  - Next clock: pc_valid_o ← 1, state → RUN, pc_o unchanged.
  - Jump, branch and stall inputs are ignored while in REDIR.
- Arithmetic rules:
  - inc_i is zero-extended and br_off_i is sign-extended to PC_W.
  - All sums wrap modulo 2^PC_W. No saturation and no error.
  - If OFF_W > PC_W, br_off_i is truncated to PC_W after sign extension.
- redirect_o is high for exactly one cycle per accepted redirect.
- Simultaneous jmp_i and br_taken_i: the jump wins and the branch is dropped.
- rst_n asserted mid-REDIR or mid-HOLD: immediate return to reset values.
- inc_i = 0 in RUN: the PC is held while pc_valid_o stays 1. This is legal and is not a stall.

Optional Feature:
- Macro: PC_WRAP_FLAG_EN.
- Defined: adds output wrap_o (1 bit, registered, reset 0).
  - Pulses for one cycle when an increment-path update carries out of bit PC_W-1.
  - Jump and branch updates never set wrap_o.
- Undefined: no wrap_o port and no carry logic. Behaviour is otherwise identical.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum pc_state_e {BOOT, RUN, HOLD, REDIR}
  - default width constants
  - function sext_off(): sign-extend or truncate to PC_W
- One natural sub-module, pc_next_adder: combinational PC_W adder.
  - Takes the zero-extended increment or the sign-extended offset, selected by a mux.
  - Outputs sum and carry-out; the carry-out feeds wrap_o.

Test Plan:
- Reset release with inc_i = 4 → cycle 1: pc_o = 0x00, pc_valid_o = 1; then 0x04, 0x08, 0x0C on successive clocks.
- pc_o = 0xFC, inc_i = 4 → pc_o = 0x00 next cycle; wrap_o pulses once when PC_WRAP_FLAG_EN is defined.
- pc_o = 0x20, br_taken_i = 1, br_off_i = 0xF0 (−16) → pc_o = 0x10, redirect_o = 1 for one cycle, pc_valid_o = 0 for one cycle, then 0x10 valid with advance resuming.
- jmp_i = 1 with jmp_tgt_i = 0x80 and br_taken_i = 1 in the same cycle → pc_o = 0x80; the branch is ignored.
- stall_i high for 3 cycles at pc_o = 0x14 → pc_o stays 0x14 with pc_valid_o = 1; after release, 0x14 is held one more cycle, then 0x18 (inc_i = 4).
- rst_n pulled low during REDIR after a jump to 0x40 → pc_o = RESET_PC and pc_valid_o = 0 immediately; BOOT sequence repeats.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types, default widths and offset-extension helper for the PC sequencer.
package pc_seq_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int INC_W_DEF = 3;
  localparam int OFF_W_DEF = 8;
  // Working width for offset extension; callers cast the result down to PC_W.
  localparam int SEXT_W    = 64;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    REDIR = 2'd3
  } pc_state_e;

  // Sign-extend the low off_w bits of off to SEXT_W bits. Truncation to PC_W
  // (when the offset is wider than the PC) is done by the caller's cast.
  function automatic logic [SEXT_W-1:0] sext_off(input logic [SEXT_W-1:0] off,
                                                 input int off_w);
    logic [SEXT_W-1:0] shl;
    shl = off << (SEXT_W - off_w);
    return $unsigned($signed(shl) >>> (SEXT_W - off_w));
  endfunction

endpackage

// File: rtl/pc_next_adder.sv
// Combinational next-PC adder: pc + (zero-extended increment | sign-extended offset).
// The carry-out port only exists when PC_WRAP_FLAG_EN is defined.
module pc_next_adder import pc_seq_pkg::*; #(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] inc_ext_i,
  input  logic [PC_W-1:0] off_ext_i,
  input  logic            sel_off_i,
  output logic [PC_W-1:0] sum_o
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic            carry_o
`endif
);

  logic [PC_W-1:0] operand;

  // Select the addend: branch offset when a branch is taken, else the step.
  always_comb begin
    operand = sel_off_i ? off_ext_i : inc_ext_i;
  end

`ifdef PC_WRAP_FLAG_EN
  logic [PC_W:0] full_sum;

  // Widened add so the carry out of bit PC_W-1 is visible.
  always_comb begin
    full_sum = {1'b0, pc_i} + {1'b0, operand};
    sum_o    = full_sum[PC_W-1:0];
    carry_o  = full_sum[PC_W];
  end
`else
  // Plain modulo-2^PC_W add.
  always_comb begin
    sum_o = pc_i + operand;
  end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Registered fetch-stage program-counter sequencer (BOOT/RUN/HOLD/REDIR).
// Optional macro PC_WRAP_FLAG_EN adds a registered wrap_o pulse on increment carry-out.
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int PC_W     = PC_W_DEF,
  parameter int INC_W    = INC_W_DEF,
  parameter int OFF_W    = OFF_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic [INC_W-1:0] inc_i,
  input  logic             br_taken_i,
  input  logic [OFF_W-1:0] br_off_i,
  input  logic             jmp_i,
  input  logic [PC_W-1:0]  jmp_tgt_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic             redirect_o
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrap_o
`endif
);

  pc_state_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  logic            redirect_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] inc_ext;
  logic [PC_W-1:0] off_ext;

  // Extend both addends to PC_W; a wider offset is truncated after sign extension.
  always_comb begin
    inc_ext = PC_W'(inc_i);
    off_ext = PC_W'(sext_off(SEXT_W'(br_off_i), OFF_W));
  end

`ifdef PC_WRAP_FLAG_EN
  logic carry_d;
  logic wrap_q;

  pc_next_adder #(.PC_W(PC_W)) u_adder (
    .pc_i      (pc_q),
    .inc_ext_i (inc_ext),
    .off_ext_i (off_ext),
    .sel_off_i (br_taken_i),
    .sum_o     (pc_d),
    .carry_o   (carry_d)
  );

  // Wrap flag: one-cycle pulse only for increment-path updates that carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= (state_q == RUN) && !jmp_i && !br_taken_i && !stall_i && carry_d;
    end
  end

  assign wrap_o = wrap_q;
`else
  pc_next_adder #(.PC_W(PC_W)) u_adder (
    .pc_i      (pc_q),
    .inc_ext_i (inc_ext),
    .off_ext_i (off_ext),
    .sel_off_i (br_taken_i),
    .sum_o     (pc_d)
  );
`endif

  // Sequencer FSM with registered PC, valid and redirect outputs.
  // Priority in RUN/HOLD: jump > branch > stall > increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= PC_W'(RESET_PC);
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN, HOLD: begin
          if (jmp_i) begin
            pc_q       <= jmp_tgt_i;
            redirect_q <= 1'b1;
            valid_q    <= 1'b0;
            state_q    <= REDIR;
          end else if (br_taken_i) begin
            pc_q       <= pc_d;
            redirect_q <= 1'b1;
            valid_q    <= 1'b0;
            state_q    <= REDIR;
          end else if (stall_i) begin
            valid_q <= 1'b1;
            state_q <= HOLD;
          end else if (state_q == HOLD) begin
            // Leaving a stall refetches the held address once before advancing.
            valid_q <= 1'b1;
            state_q <= RUN;
          end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
          end
        end
        REDIR: begin
          valid_q <= 1'b1;
          state_q <= RUN;
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = valid_q;
  assign redirect_o = redirect_q;

endmodule
